// File: rtl/risc_pkg.sv
// Shared RISC-V decode constants and the fetch/decode queue entry layout.
// The sign-extension unit uses the same IMM_* encodings.
package risc_pkg;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_LOAD_FP = 7'b0000111;
    localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_STORE_FP= 7'b0100111;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [2:0]  imm_src;
        logic        imm_used;
    } fdq_entry_t;

endpackage

// File: rtl/fetch_decode_queue_imm_predecode.sv
// Opcode to immediate-format pre-decode, evaluated on the enqueue path.
// Opcodes without an immediate (OP, OP-FP, SYSTEM, unknown) report imm_used=0.
module imm_predecode
    import risc_pkg::*;
(
    input  logic [6:0] i_opcode,
    output logic [2:0] o_imm_src,
    output logic       o_imm_used
);

    always_comb begin
        o_imm_src  = IMM_I;
        o_imm_used = 1'b0;
        case (i_opcode)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_LOAD_FP: begin
                o_imm_src  = IMM_I;
                o_imm_used = 1'b1;
            end
            OPC_STORE, OPC_STORE_FP: begin
                o_imm_src  = IMM_S;
                o_imm_used = 1'b1;
            end
            OPC_BRANCH: begin
                o_imm_src  = IMM_B;
                o_imm_used = 1'b1;
            end
            OPC_JAL: begin
                o_imm_src  = IMM_J;
                o_imm_used = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                o_imm_src  = IMM_U;
                o_imm_used = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/fetch_decode_queue.sv
// Instruction queue between fetch and decode; stores {pc, instr, imm_src, imm_used}
// per entry so decode sees a registered immediate format. Flush empties the queue.
module fetch_decode_queue
    import risc_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr,
    output logic [2:0]      out_imm_src,
    output logic            out_imm_used
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    fdq_entry_t    r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic          w_push;
    logic          w_pop;
    logic [2:0]    w_imm_src;
    logic          w_imm_used;
    fdq_entry_t    w_head;

    imm_predecode u_imm_predecode (
        .i_opcode   (in_instr[6:0]),
        .o_imm_src  (w_imm_src),
        .o_imm_used (w_imm_used)
    );

    // in_ready comes only from the registered count, never from out_ready
    assign in_ready  = (r_count != FULL_CNT);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_mem[r_wr_ptr] <= '{pc: in_pc, instr: in_instr,
                                 imm_src: w_imm_src, imm_used: w_imm_used};
        end
    end

    assign w_head       = r_mem[r_rd_ptr];
    assign out_pc       = out_valid ? w_head.pc       : '0;
    assign out_instr    = out_valid ? w_head.instr    : INSTR_NOP;
    assign out_imm_src  = out_valid ? w_head.imm_src  : IMM_I;
    assign out_imm_used = out_valid ? w_head.imm_used : 1'b0;

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Scoreboard bench for fetch_decode_queue: directed pushes record expected entries,
// a negedge monitor pops and compares every consumed head.
module tb_fetch_decode_queue;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [2:0]  imm_src;
        logic        imm_used;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_imm_used;
    logic [31:0] in_pc, in_instr, out_pc, out_instr;
    logic [2:0]  out_imm_src;
    logic [2:0]  tb_exp_src;
    logic        tb_exp_used;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q[$];
    exp_t sb_e;

    localparam logic [31:0] NOP = 32'h0000_0013;

    fetch_decode_queue #(.DEPTH(2), .XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
        .out_imm_src(out_imm_src), .out_imm_used(out_imm_used)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_word(input logic [31:0] pc, input logic [31:0] instr,
                              input logic [2:0] src, input logic used);
        in_valid    = 1'b1;
        in_pc       = pc;
        in_instr    = instr;
        tb_exp_src  = src;
        tb_exp_used = used;
    endtask

    always @(negedge clk) begin
        if (rst_n && !flush) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_unexpected: got pc=%h instr=%h, required no output", out_pc, out_instr);
                end else begin
                    sb_e = exp_q.pop_front();
                    check("sb_pc", out_pc, sb_e.pc);
                    check("sb_instr", out_instr, sb_e.instr);
                    check("sb_imm_src", {29'b0, out_imm_src}, {29'b0, sb_e.imm_src});
                    check("sb_imm_used", {31'b0, out_imm_used}, {31'b0, sb_e.imm_used});
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back('{pc: in_pc, instr: in_instr, imm_src: tb_exp_src, imm_used: tb_exp_used});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    logic [31:0] sw_instr [9];
    logic [2:0]  sw_src   [9];
    logic        sw_used  [9];

    initial begin
        sw_instr = '{32'hFE000EE3, 32'h0000006F, 32'h12345037, 32'h00B50533, 32'h00052007,
                     32'h00A52027, 32'h00000517, 32'h000080E7, 32'h00000073};
        sw_src   = '{3'b010, 3'b011, 3'b100, 3'b000, 3'b000, 3'b001, 3'b100, 3'b000, 3'b000};
        sw_used  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_instr = '0; tb_exp_src = '0; tb_exp_used = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_out_instr", out_instr, NOP);
        check("rst_imm_src", {29'b0, out_imm_src}, 32'd0);
        check("rst_imm_used", 32'(out_imm_used), 32'd0);
        tick();
        rst_n = 1'b1;

        // T1: asynchronous reset with two entries buffered
        drive_word(32'h100, 32'h00500093, 3'b000, 1'b1);
        tick();
        drive_word(32'h104, 32'h00112023, 3'b001, 1'b1);
        tick();
        in_valid = 1'b0;
        check("t1_count_before", 32'(dut.r_count), 32'd2);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("t1_out_valid", 32'(out_valid), 32'd0);
        check("t1_in_ready", 32'(in_ready), 32'd1);
        check("t1_out_instr", out_instr, NOP);
        check("t1_count", 32'(dut.r_count), 32'd0);
        tick();
        rst_n = 1'b1;

        // T2: fill then drain in order
        drive_word(32'h200, 32'h00500093, 3'b000, 1'b1);
        tick();
        check("t2_ready_one", 32'(in_ready), 32'd1);
        drive_word(32'h204, 32'h00112023, 3'b001, 1'b1);
        tick();
        in_valid = 1'b0;
        check("t2_ready_full", 32'(in_ready), 32'd0);
        check("t2_out_valid", 32'(out_valid), 32'd1);
        check("t2_head_src", {29'b0, out_imm_src}, 32'd0);
        check("t2_head_instr", out_instr, 32'h00500093);
        out_ready = 1'b1;
        tick();
        check("t2_second_src", {29'b0, out_imm_src}, 32'd1);
        check("t2_second_pc", out_pc, 32'h204);
        tick();
        check("t2_empty_valid", 32'(out_valid), 32'd0);
        check("t2_empty_instr", out_instr, NOP);
        out_ready = 1'b0;

        // T3: full with push and pop requested together
        drive_word(32'h300, 32'hFE000EE3, 3'b010, 1'b1);
        tick();
        drive_word(32'h304, 32'h0000006F, 3'b011, 1'b1);
        tick();
        drive_word(32'h308, 32'h12345037, 3'b100, 1'b1);
        out_ready = 1'b1;
        #1;
        check("t3_full_ready", 32'(in_ready), 32'd0);
        tick();
        check("t3_count_after_pop", 32'(dut.r_count), 32'd1);
        check("t3_ready_after_pop", 32'(in_ready), 32'd1);
        check("t3_head_pc", out_pc, 32'h304);
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        check("t3_count_after_push", 32'(dut.r_count), 32'd2);
        out_ready = 1'b1;
        tick(2);
        check("t3_drained", 32'(dut.r_count), 32'd0);
        out_ready = 1'b0;

        // T4: flush beats simultaneous push and pop
        drive_word(32'h400, 32'h00000517, 3'b100, 1'b1);
        tick();
        drive_word(32'h404, 32'h00A52027, 3'b001, 1'b1);
        tick();
        flush = 1'b1;
        drive_word(32'h408, 32'h00000073, 3'b000, 1'b0);
        out_ready = 1'b1;
        exp_q.delete();
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        check("t4_count", 32'(dut.r_count), 32'd0);
        check("t4_out_valid", 32'(out_valid), 32'd0);
        check("t4_in_ready", 32'(in_ready), 32'd1);
        check("t4_out_instr", out_instr, NOP);
        drive_word(32'h40C, 32'h000080E7, 3'b000, 1'b1);
        tick();
        in_valid = 1'b0;
        check("t4_new_head_pc", out_pc, 32'h40C);
        check("t4_new_count", 32'(dut.r_count), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t4_drained", 32'(dut.r_count), 32'd0);

        // T5: pre-decode sweep through the scoreboard
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            drive_word(32'h500 + 32'(4 * i), sw_instr[i], sw_src[i], sw_used[i]);
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("t5_drained", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // T6: streaming at count=1
        drive_word(32'h1000, 32'h00100093, 3'b000, 1'b1);
        tick();
        check("t6_start_count", 32'(dut.r_count), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive_word(32'h1004 + 32'(4 * i), 32'h00100093, 3'b000, 1'b1);
            tick();
            check("t6_count", 32'(dut.r_count), 32'd1);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4 && out_valid; i++) tick();
        check("t6_drained", 32'(out_valid), 32'd0);
        out_ready = 1'b0;
        tick();

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
